// File: rtl/perm_pkg.sv
// Shared constants, factorial table and FSM state type for the 7-input permutation unranker.
package perm_pkg;

    localparam int N        = 7;
    localparam int RANK_W   = 13;
    localparam int IDX_W    = 3;
    localparam int PRM_W    = 21;
    localparam int RANK_MAX = 5040;

    localparam logic [RANK_W-1:0] FACT [0:N-1] = '{
        13'd1, 13'd1, 13'd2, 13'd6, 13'd24, 13'd120, 13'd720
    };

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/perm_pick_nth.sv
// Returns the bit position of the n-th set bit of a 7-bit mask, counting from the LSB at 0.
module perm_pick_nth
    import perm_pkg::*;
(
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_n,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        o_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_mask[i]) begin
                if (w_cnt == {1'b0, i_n}) o_idx = IDX_W'(i);
                w_cnt = w_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/unrank_perm.sv
// Maps a lexicographic rank 0..5039 to its permutation of 7 indices, one factorial digit per cycle.
module unrank_perm
    import perm_pkg::*;
#(
    parameter int N = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RANK_W-1:0]    in_rank,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W*N-1:0]   out_prm,
    output logic                 out_err
);

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_step;
    logic [N-1:0]           r_mask;
    logic [RANK_W-1:0]      r_rem;
    logic [IDX_W*N-1:0]     r_prm;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_bad;
    logic [RANK_W-1:0]      w_fact;
    logic [RANK_W-1:0]      w_sub;
    logic [IDX_W-1:0]       w_d;
    logic [IDX_W-1:0]       w_pick;

    assign w_accept = in_valid && in_ready;
    assign w_bad    = (in_rank >= RANK_W'(RANK_MAX));
    assign w_fact   = FACT[3'd6 - r_step];

    // Digit d is the largest j with j*(6-k)! <= remainder; the multiples never exceed 13 bits.
    always_comb begin
        logic [RANK_W-1:0] prod;
        w_d   = '0;
        w_sub = '0;
        prod  = '0;
        for (int unsigned j = 1; j < N; j++) begin
            prod = RANK_W'(j) * w_fact;
            if (r_rem >= prod) begin
                w_d   = IDX_W'(j);
                w_sub = prod;
            end
        end
    end

    perm_pick_nth u_pick (
        .i_mask (r_mask),
        .i_n    (w_d),
        .o_idx  (w_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_prm   = r_prm;
        out_err   = r_err;
        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (w_accept) w_next = w_bad ? DONE : CALC;
            end
            CALC: if (r_step == 3'd6) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= '0;
            r_mask <= '1;
            r_rem  <= '0;
            r_prm  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_step <= '0;
                    r_mask <= '1;
                    r_rem  <= in_rank;
                    r_prm  <= '0;
                    r_err  <= w_bad;
                end
                CALC: begin
                    r_prm[IDX_W*r_step +: IDX_W] <= w_pick;
                    r_mask[w_pick]               <= 1'b0;
                    r_rem                        <= r_rem - w_sub;
                    r_step                       <= r_step + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unrank_perm.sv
// Directed and exhaustive checks of unrank_perm against hand-derived permutations and a Lehmer-code ranker.
module tb_unrank_perm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_rank;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_prm;
    logic        out_err;

    int n_tot = 0;
    int n_bad = 0;

    unrank_perm #(.N(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rank   (in_rank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prm   (out_prm),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] pk(input int unsigned a0, a1, a2, a3, a4, a5, a6);
        return {3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    // Lehmer-code ranker; valid=0 if any field is out of range or repeated.
    function automatic int unsigned rank_of(input logic [20:0] p, output bit valid);
        int unsigned f[7];
        int unsigned fct[7] = '{720, 120, 24, 6, 2, 1, 1};
        int unsigned r = 0;
        bit [7:0] used = '0;
        valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            f[k] = int'(p[3*k +: 3]);
            if (f[k] > 6 || used[f[k]]) valid = 1'b0;
            used[f[k]] = 1'b1;
        end
        for (int k = 0; k < 7; k++) begin
            int unsigned c = 0;
            for (int j = k + 1; j < 7; j++) if (f[j] < f[k]) c++;
            r += c * fct[k];
        end
        return r;
    endfunction

    task automatic run(input logic [12:0] rk, output logic [20:0] prm, output logic err,
                       output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_rank  = rk;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        prm = out_prm;
        err = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [12:0] v_rank [8];
    logic [20:0] v_prm  [8];
    logic        v_err  [8];
    int          v_lat  [8];

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [20:0] prm;
        logic        err;
        int          lat;
        bit          valid;
        int unsigned r;
        bit          seen [0:5039];

        v_rank[0] = 13'd0;    v_prm[0] = pk(0,1,2,3,4,5,6); v_err[0] = 0; v_lat[0] = 8;
        v_rank[1] = 13'd5039; v_prm[1] = pk(6,5,4,3,2,1,0); v_err[1] = 0; v_lat[1] = 8;
        v_rank[2] = 13'd1;    v_prm[2] = pk(0,1,2,3,4,6,5); v_err[2] = 0; v_lat[2] = 8;
        v_rank[3] = 13'd2160; v_prm[3] = pk(3,0,1,2,4,5,6); v_err[3] = 0; v_lat[3] = 8;
        v_rank[4] = 13'd2520; v_prm[4] = pk(3,4,0,1,2,5,6); v_err[4] = 0; v_lat[4] = 8;
        v_rank[5] = 13'd100;  v_prm[5] = pk(0,1,6,2,5,3,4); v_err[5] = 0; v_lat[5] = 8;
        v_rank[6] = 13'd5040; v_prm[6] = '0;                v_err[6] = 1; v_lat[6] = 1;
        v_rank[7] = 13'd8191; v_prm[7] = '0;                v_err[7] = 1; v_lat[7] = 1;

        rst = 1'b1; in_valid = 1'b0; in_rank = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_prm",   out_prm,   0);
        check("rst_out_err",   out_err,   0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run(v_rank[i], prm, err, lat);
            check($sformatf("prm_r%0d", v_rank[i]), prm, v_prm[i]);
            check($sformatf("err_r%0d", v_rank[i]), err, v_err[i]);
            check($sformatf("lat_r%0d", v_rank[i]), lat, v_lat[i]);
            check($sformatf("idle_r%0d", v_rank[i]), in_ready, 1);
        end

        // Back-pressure: results must hold in DONE while out_ready stays low.
        in_valid = 1'b1; in_rank = 13'd2520;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("hold_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_prm",   out_prm,   pk(3,4,0,1,2,5,6));
            check("hold_err",   out_err,   0);
            check("hold_ready", in_ready,  0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready",  in_ready,  1);
        check("release_out_valid", out_valid, 0);

        // Abort mid-computation at step 3.
        in_valid = 1'b1; in_rank = 13'd4000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("calc_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready",  in_ready,  0);
        check("abort_out_prm",   out_prm,   0);
        @(posedge clk); #1;
        check("abort_hold_valid", out_valid, 0);
        check("abort_hold_ready", in_ready,  0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_rel_ready", in_ready,  1);
        check("abort_rel_valid", out_valid, 0);
        run(13'd1, prm, err, lat);
        check("abort_r1_prm", prm, pk(0,1,2,3,4,6,5));
        check("abort_r1_err", err, 0);
        check("abort_r1_lat", lat, 8);

        for (int i = 0; i < 5040; i++) seen[i] = 1'b0;
        for (int i = 0; i < 5040; i++) begin
            run(13'(i), prm, err, lat);
            r = rank_of(prm, valid);
            check("sweep_rank",  r,     i);
            check("sweep_valid", valid, 1);
            check("sweep_err",   err,   0);
            if (r < 5040) begin
                check("sweep_unique", seen[r], 0);
                seen[r] = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
